mdio_master_ctrl: RTL
=====================

# mdio_master_ctrl

MDIO management-station controller that sequences complete Clause-22 MDIO transactions onto the serial management bus that feeds `receptorMDIO`. It accepts a 32-bit frame request and drives an optional all-ones preamble and the frame MSB-first, handling `MDIO_OE` ownership. For reads it releases the bus at turnaround, shifts in 16 data bits from the PHY side, and reports completion with a one-cycle strobe.

## Interface
- `PRE_LEN`, 32: number of preamble bits (all ones) driven before the frame; legal range 0..32.
- `MDC` in 1: management clock. All logic uses the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `MDIO_START` in 1: transaction request, sampled only in IDLE.
- `T_DATA` in 32: frame, transmitted MSB first. Fields:
  - [31:30] ST = 01
  - [29:28] OP: 01 write, 10 read
  - [27:23] PHY address
  - [22:18] register address
  - [17:16] TA
  - [15:0] data
- `MDIO_IN` in 1: serial data returned by the PHY side.
- `MDIO_OUT` out 1: serial data to the PHY side.
- `MDIO_OE` out 1: high while this block drives `MDIO_OUT`.
- `RD_DATA` out 16: last word captured by a read.
- `MDIO_DONE` out 1: one-cycle pulse at the end of every transaction.
- `BUSY` out 1: high from request acceptance until the transaction ends.

## Operation
- States are IDLE, PREAMBLE, DRIVE, READ_TA and READ_DATA.
- A 6-bit bit counter and a 32-bit shift register hold the frame. A 16-bit input shift register collects read data.
- **IDLE:**
  - `MDIO_START`=1 latches `T_DATA` and sets `BUSY`=1 and `MDIO_OE`=1.
  - The state goes to PREAMBLE if `PRE_LEN`>0, else to DRIVE.
- **PREAMBLE:** `MDIO_OUT`=1 for `PRE_LEN` cycles, then DRIVE.
- **DRIVE:** `MDIO_OUT` carries frame bit 31 downward, one bit per cycle.
- **Read detection:** a transaction is a read when latched OP = 10. Every other OP value (00, 01, 11) is a write.
- **Write path:** all 32 frame bits are driven. After bit 0, the state returns to IDLE with `MDIO_OE`=0, `BUSY`=0 and `MDIO_DONE`=1 for one cycle. `RD_DATA` is unchanged.
- **Read path:**
  - Only bits 31..18 (14 bits) are driven, then the state goes to READ_TA with `MDIO_OE`=0.
  - READ_TA lasts 2 cycles, and `MDIO_IN` is ignored during it.
  - READ_DATA samples `MDIO_IN` for 16 cycles, MSB first.
  - On the final sample `RD_DATA` is updated with the full word and `MDIO_DONE` pulses. `RD_DATA` never shows partial words.
- `MDIO_START` while `BUSY`=1 is ignored and is not queued.
- `T_DATA` is don't-care except at the acceptance edge.
- `MDIO_OUT` is 0 whenever `MDIO_OE`=0.

## Timing
- **Reset values:**
  - state = IDLE
  - `MDIO_OUT`=0, `MDIO_OE`=0, `BUSY`=0, `MDIO_DONE`=0
  - `RD_DATA`=16'h0000
  - counters and shift registers = 0
- **Reset mid-transaction:** at the next rising edge all of the above values apply. No `MDIO_DONE` is issued and `RD_DATA` is cleared.
- **Acceptance edge E0:** all outputs are registered. Frame bit (31−k) is on `MDIO_OUT` during cycle `PRE_LEN`+k after E0.
- **Write:**
  - `MDIO_OE` is high for `PRE_LEN`+32 cycles.
  - `MDIO_DONE` is high during cycle `PRE_LEN`+32 after E0, the same cycle `BUSY` falls.
- **Read:**
  - `MDIO_OE` is high for `PRE_LEN`+14 cycles.
  - Data bit 15 is sampled at the edge ending cycle `PRE_LEN`+16.
  - `RD_DATA` is valid and `MDIO_DONE`=1 in cycle `PRE_LEN`+32.
- **Back-to-back:** a new `MDIO_START` is accepted at the same edge that ends the `MDIO_DONE` cycle. Minimum spacing between acceptances is `PRE_LEN`+33 cycles.
- **`MDIO_START` with `reset`:** if both are high on the same edge, reset wins.

## Test plan
- **Reset:** `reset`=1 for 2 edges → all outputs at reset values. `MDIO_START`=1 during reset → no transaction begins.
- **Write, `PRE_LEN`=0:**
  - Stimulus: `T_DATA`=32'h5251_5555 and a 1-cycle `MDIO_START`.
  - `MDIO_OUT` serial = 0101 0010 0101 0001 0101…0101 over 32 cycles, with `MDIO_OE`=1 throughout.
  - Then `MDIO_DONE` pulses once and `RD_DATA` stays 0.
- **Read, `PRE_LEN`=0:**
  - Stimulus: `T_DATA`=32'h6252_0000, with the bench driving `MDIO_IN` with 16'hAAAA after TA.
  - `MDIO_OE` falls after 14 bits.
  - `RD_DATA`=16'hAAAA and `MDIO_DONE`=1 in cycle 32.
- **Preamble, `PRE_LEN`=32:** write request → 32 cycles of `MDIO_OUT`=1 precede the frame, and `MDIO_DONE` arrives in cycle 64.
- **Busy/back-to-back:**
  - A second `MDIO_START` mid-write is ignored, with no change to the frame.
  - A start at the edge ending the `MDIO_DONE` cycle is accepted, and the next frame begins immediately.
- **Reset mid-read:** `reset` asserted at data bit 8 → next cycle `MDIO_OE`=0 and `BUSY`=0, no `MDIO_DONE`, `RD_DATA`=0. A subsequent read completes normally.

Source files
------------

// File: rtl/mdio_master_ctrl.sv
// Clause-22 MDIO management-station controller.
// Sends an optional all-ones preamble and then a 32-bit frame, MSB first.
// For a read (OP=10) only the 14 header bits are driven. The bus is then
// released for the 2-cycle turnaround, and 16 data bits are shifted in.
// All outputs are registered. The cycle after the acceptance edge is
// cycle 0, and frame bit (31-k) is on MDIO_OUT in cycle PRE_LEN+k.
module mdio_master_ctrl #(
  parameter int PRE_LEN = 32
) (
  input  logic        MDC,
  input  logic        reset,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        MDIO_DONE,
  output logic        BUSY
);

  localparam logic       HAS_PRE  = (PRE_LEN > 0);
  localparam logic [5:0] PRE_LAST = HAS_PRE ? 6'(PRE_LEN - 1) : 6'd0;

  typedef enum logic [2:0] {IDLE, PREAMBLE, DRIVE, READ_TA, READ_DATA} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [31:0] tx_sh, tx_sh_nxt;
  logic [15:0] rx_sh, rx_sh_nxt;
  logic        is_rd, is_rd_nxt;
  logic        out_nxt, oe_nxt, done_nxt, busy_nxt;
  logic [15:0] rd_nxt;

  // State, datapath and registered outputs; reset wins over a start request
  always_ff @(posedge MDC) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      is_rd     <= 1'b0;
      MDIO_OUT  <= 1'b0;
      MDIO_OE   <= 1'b0;
      RD_DATA   <= '0;
      MDIO_DONE <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tx_sh     <= tx_sh_nxt;
      rx_sh     <= rx_sh_nxt;
      is_rd     <= is_rd_nxt;
      MDIO_OUT  <= out_nxt;
      MDIO_OE   <= oe_nxt;
      RD_DATA   <= rd_nxt;
      MDIO_DONE <= done_nxt;
      BUSY      <= busy_nxt;
    end
  end

  // Next-state and next-output logic. The values computed here are what
  // the bus shows in the cycle after the coming edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tx_sh_nxt = tx_sh;
    rx_sh_nxt = rx_sh;
    is_rd_nxt = is_rd;
    out_nxt   = MDIO_OUT;
    oe_nxt    = MDIO_OE;
    rd_nxt    = RD_DATA;
    done_nxt  = 1'b0;
    busy_nxt  = BUSY;
    case (state)
      IDLE: begin
        if (MDIO_START) begin
          is_rd_nxt = (T_DATA[29:28] == 2'b10);
          busy_nxt  = 1'b1;
          oe_nxt    = 1'b1;
          cnt_nxt   = '0;
          if (HAS_PRE) begin
            state_nxt = PREAMBLE;
            tx_sh_nxt = T_DATA;
            out_nxt   = 1'b1;
          end else begin
            // No preamble, so bit 31 is already on the bus in cycle 0.
            state_nxt = DRIVE;
            out_nxt   = T_DATA[31];
            tx_sh_nxt = {T_DATA[30:0], 1'b0};
          end
        end
      end
      PREAMBLE: begin
        if (cnt == PRE_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
          out_nxt   = tx_sh[31];
          tx_sh_nxt = {tx_sh[30:0], 1'b0};
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      DRIVE: begin
        if (!is_rd && cnt == 6'd31) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          oe_nxt    = 1'b0;
          out_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (is_rd && cnt == 6'd13) begin
          // Header is complete, so release the bus for the PHY turnaround.
          state_nxt = READ_TA;
          cnt_nxt   = '0;
          oe_nxt    = 1'b0;
          out_nxt   = 1'b0;
        end else begin
          out_nxt   = tx_sh[31];
          tx_sh_nxt = {tx_sh[30:0], 1'b0};
          cnt_nxt   = cnt + 6'd1;
        end
      end
      READ_TA: begin
        if (cnt == 6'd1) begin
          state_nxt = READ_DATA;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      READ_DATA: begin
        rx_sh_nxt = {rx_sh[14:0], MDIO_IN};
        if (cnt == 6'd15) begin
          // RD_DATA is loaded only here, so a partial word is never visible.
          rd_nxt    = {rx_sh[14:0], MDIO_IN};
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
